// File: rtl/alm_cell.sv
// alm_cell: adaptive logic module with four 4-LUTs, 6-LUT mode, carry chain and two registers.
// Optional ALM_CONFIG_OUT_EN drives config_out from the top of the configuration chain.
module alm_cell #(
    parameter int param_XOR6_en   = 1,
    parameter int param_MajAdd_en = 0,
    parameter int param_fixed     = 1
) (
    input  logic clk,
    input  logic clear,
    input  logic clear_sync_0,
    input  logic clear_sync_1,
    input  logic clk_en_0,
    input  logic clk_en_1,
    input  logic DataA,
    input  logic DataB,
    input  logic DataC0,
    input  logic DataC1,
    input  logic DataD0,
    input  logic DataD1,
    input  logic DataE,
    input  logic DataF,
    input  logic carry_in,
    output logic carry_out,
    output logic out_0,
    output logic out_1,
    output logic out_2,
    output logic out_3,
    input  logic config_in,
    input  logic config_en,
    output logic config_out
);

    localparam int EXT = (param_XOR6_en != 0 || param_MajAdd_en != 0) ? 1 : 0;
    localparam int MAJ = (param_MajAdd_en != 0) ? 1 : 0;
    localparam int N   = 86 + EXT + MAJ;

    logic [N-1:0] cfg;
    logic [15:0]  lut0, lut1, lut2, lut3;
    logic [3:0]   idx_lo, idx_hi;
    logic         l0, l1, l2, l3;
    logic         mode6, arith;
    logic         xor6_on, majadd_on;
    logic         cin0, s0, c1, s1, co;
    logic         comb0, comb1;
    logic         d0, d1;
    logic         reg0, reg1;
    logic         unused_rsv;

    // Serial configuration chain, MSB first; not touched by clear
    always_ff @(posedge clk) begin
        if (config_en) begin
            cfg <= {cfg[N-2:0], config_in};
        end
    end

    assign lut0  = cfg[15:0];
    assign lut1  = cfg[31:16];
    assign lut2  = cfg[47:32];
    assign lut3  = cfg[63:48];
    assign mode6 = cfg[64];
    assign arith = cfg[65] & ~cfg[64];

    assign unused_rsv = ^{cfg[85:78], cfg[75:70]};

    generate
        if (param_XOR6_en != 0) begin : g_x6
            assign xor6_on = cfg[86];
        end else begin : g_nox6
            assign xor6_on = 1'b0;
            if (N > 86) begin : g_pad
                logic unused_x6;
                assign unused_x6 = cfg[(N > 86) ? 86 : 0];
            end
        end
        if (MAJ != 0) begin : g_maj
            assign majadd_on = cfg[(MAJ != 0) ? 87 : 0];
        end else begin : g_nomaj
            assign majadd_on = 1'b0;
        end
    endgenerate

    // In 6-LUT mode the upper LUTs share the lower input set
    assign idx_lo = {DataD0, DataC0, DataB, DataA};
    assign idx_hi = mode6 ? idx_lo : {DataD1, DataC1, DataB, DataA};

    assign l0 = lut0[idx_lo];
    assign l1 = lut1[idx_lo];
    assign l2 = lut2[idx_hi];
    assign l3 = lut3[idx_hi];

    assign cin0 = majadd_on ? DataE : carry_in;
    assign s0   = l0 ^ l1 ^ cin0;
    assign c1   = (l0 & l1) | (l0 & cin0) | (l1 & cin0);
    assign s1   = l2 ^ l3 ^ c1;
    assign co   = (l2 & l3) | (l2 & c1) | (l3 & c1);

    assign carry_out = arith ? co : 1'b0;

    // Result selection: normal pair, 6-LUT, adder; XOR6 overrides comb0
    always_comb begin
        comb0 = DataE ? l1 : l0;
        comb1 = DataF ? l3 : l2;
        if (mode6) begin
            unique case ({DataF, DataE})
                2'b00:   comb1 = l0;
                2'b01:   comb1 = l1;
                2'b10:   comb1 = l2;
                default: comb1 = l3;
            endcase
        end else if (arith) begin
            comb0 = s0;
            comb1 = s1;
        end
        if (xor6_on) begin
            comb0 = DataA ^ DataB ^ DataC0 ^ DataD0 ^ DataE ^ DataF;
        end
    end

    assign d0 = cfg[76] ? DataE : comb0;
    assign d1 = cfg[77] ? DataF : comb1;

    // reg0: clear, then per-register clear, then enable
    always_ff @(posedge clk) begin
        if (clear) begin
            reg0 <= 1'b0;
        end else if (clear_sync_0) begin
            reg0 <= 1'b0;
        end else if (clk_en_0) begin
            reg0 <= d0;
        end
    end

    // reg1: clear, then per-register clear, then enable
    always_ff @(posedge clk) begin
        if (clear) begin
            reg1 <= 1'b0;
        end else if (clear_sync_1) begin
            reg1 <= 1'b0;
        end else if (clk_en_1) begin
            reg1 <= d1;
        end
    end

    generate
        if (param_fixed != 0) begin : g_fixed
            logic unused_sel;
            assign unused_sel = ^cfg[69:66];
            assign out_0 = comb0;
            assign out_1 = reg0;
            assign out_2 = comb1;
            assign out_3 = reg1;
        end else begin : g_route
            assign out_0 = cfg[66] ? reg0 : comb0;
            assign out_1 = cfg[67] ? reg0 : comb0;
            assign out_2 = cfg[68] ? reg1 : comb1;
            assign out_3 = cfg[69] ? reg1 : comb1;
        end
    endgenerate

`ifdef ALM_CONFIG_OUT_EN
    assign config_out = cfg[N-1];
`else
    assign config_out = 1'b0;
`endif

endmodule

// File: tb/tb_alm_cell.sv
// tb_alm_cell: directed bench for alm_cell with a behavioural model
// checked every cycle plus hand-computed literal expectations.
module tb_alm_cell;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clear, clear_sync_0, clear_sync_1, clk_en_0, clk_en_1;
    logic DataA, DataB, DataC0, DataC1, DataD0, DataD1, DataE, DataF;
    logic carry_in, carry_out;
    logic out_0, out_1, out_2, out_3;
    logic config_in, config_en, config_out;

    alm_cell dut (
        .clk(clk), .clear(clear),
        .clear_sync_0(clear_sync_0), .clear_sync_1(clear_sync_1),
        .clk_en_0(clk_en_0), .clk_en_1(clk_en_1),
        .DataA(DataA), .DataB(DataB), .DataC0(DataC0), .DataC1(DataC1),
        .DataD0(DataD0), .DataD1(DataD1), .DataE(DataE), .DataF(DataF),
        .carry_in(carry_in), .carry_out(carry_out),
        .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
        .config_in(config_in), .config_en(config_en), .config_out(config_out)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    logic [86:0] mcfg;
    logic        m_r0, m_r1;
    logic [7:0]  din;
    logic [2:0]  m_now;

    // {cout, comb1, comb0} from the cell's functional rules
    function automatic logic [2:0] model_comb(input logic [86:0] cf,
                                              input logic [7:0] d,
                                              input logic cin);
        logic a, b, c0, c1, d0, d1, e, f, r0, r1, co;
        int lo, hi, t, u;
        a = d[0]; b = d[1]; c0 = d[2]; c1 = d[3];
        d0 = d[4]; d1 = d[5]; e = d[6]; f = d[7];
        lo = int'({d0, c0, b, a});
        hi = int'({d1, c1, b, a});
        co = 1'b0;
        if (cf[64] === 1'b1) begin
            r0 = cf[16 * int'(e) + lo];
            r1 = cf[32 * int'(f) + 16 * int'(e) + lo];
        end else if (cf[65] === 1'b1) begin
            t = int'(cf[lo]) + int'(cf[16 + lo]) + int'(cin);
            u = int'(cf[32 + hi]) + int'(cf[48 + hi]) + ((t >= 2) ? 1 : 0);
            r0 = t[0];
            r1 = u[0];
            co = (u >= 2);
        end else begin
            r0 = e ? cf[16 + lo] : cf[lo];
            r1 = f ? cf[48 + hi] : cf[32 + hi];
        end
        if (cf[86] === 1'b1) r0 = a ^ b ^ c0 ^ d0 ^ e ^ f;
        return {co, r1, r0};
    endfunction

    assign din = {DataF, DataE, DataD1, DataD0, DataC1, DataC0, DataB, DataA};
    assign m_now = model_comb(mcfg, din, carry_in);

    // Model state: config chain and the two registers
    always @(posedge clk) begin
        if (config_en) mcfg <= {mcfg[85:0], config_in};
        if (clear || clear_sync_0) m_r0 <= 1'b0;
        else if (clk_en_0) m_r0 <= mcfg[76] ? DataE : m_now[0];
        if (clear || clear_sync_1) m_r1 <= 1'b0;
        else if (clk_en_1) m_r1 <= mcfg[77] ? DataF : m_now[1];
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model out_0", out_0, m_now[0]);
            check("model out_2", out_2, m_now[1]);
            check("model carry_out", carry_out, m_now[2]);
            check("model out_1", out_1, m_r0);
            check("model out_3", out_3, m_r1);
`ifdef ALM_CONFIG_OUT_EN
            check("model config_out", config_out, mcfg[86]);
`else
            check("config_out tied", config_out, 1'b0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shift MSB first; optionally pulse clear at one bit position
    task automatic shift_cfg(input logic [86:0] v, input int clr_at);
        for (int i = 86; i >= 0; i--) begin
            config_in = v[i];
            config_en = 1'b1;
            clear = (i == clr_at);
            step();
        end
        config_en = 1'b0;
        config_in = 1'b0;
        clear = 1'b0;
    endtask

    task automatic set6(input logic [5:0] v);
        {DataF, DataE, DataD0, DataC0, DataB, DataA} = v;
    endtask

    logic [86:0] cv;
    logic [5:0]  rv;
    int          pc;

    initial begin
        clear = 1'b1; clear_sync_0 = 1'b0; clear_sync_1 = 1'b0;
        clk_en_0 = 1'b0; clk_en_1 = 1'b0;
        {DataA, DataB, DataC0, DataC1, DataD0, DataD1, DataE, DataF} = 8'h00;
        carry_in = 1'b0; config_in = 1'b0; config_en = 1'b0;
        step();
        step();
        clear = 1'b0;
        #2;
        check("reset out_1", out_1, 1'b0);
        check("reset out_3", out_3, 1'b0);

        // 6-LUT of popcount bit1 with XOR6 on comb0
        cv = '0;
        for (int i = 0; i < 64; i++) begin
            pc = $countones(i);
            cv[i] = pc[1];
        end
        cv[64] = 1'b1;
        cv[86] = 1'b1;
        shift_cfg(cv, -1);
        chk_en = 1'b1;
        set6(6'b101101);
        #2;
        check("xor6 101101 out_0", out_0, 1'b0);
        check("lut6 101101 out_2", out_2, 1'b0);
        step();
        set6(6'b000111);
        #2;
        check("xor6 000111 out_0", out_0, 1'b1);
        check("lut6 000111 out_2", out_2, 1'b1);
        step();
        clk_en_0 = 1'b1;
        clk_en_1 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            rv = 6'($urandom_range(0, 63));
            set6(rv);
            DataC1 = 1'($urandom_range(0, 1));
            DataD1 = 1'($urandom_range(0, 1));
            pc = $countones(rv);
            #2;
            check("rand out_0", out_0, pc[0]);
            check("rand out_2", out_2, pc[1]);
            step();
        end
        clk_en_0 = 1'b0;
        clk_en_1 = 1'b0;

        // Two-bit adder: L0=A, L1=B, L2=C1, L3=D1
        cv = '0;
        cv[15:0] = 16'hAAAA;
        cv[31:16] = 16'hCCCC;
        cv[47:32] = 16'hF0F0;
        cv[63:48] = 16'hFF00;
        cv[65] = 1'b1;
        shift_cfg(cv, -1);
        {DataF, DataE, DataD0, DataC0} = 4'b0000;
        carry_in = 1'b1; DataA = 1'b1; DataB = 1'b1; DataC1 = 1'b1; DataD1 = 1'b0;
        #2;
        check("add1 out_0", out_0, 1'b1);
        check("add1 out_2", out_2, 1'b0);
        check("add1 carry_out", carry_out, 1'b1);
        step();
        carry_in = 1'b0; DataA = 1'b1; DataB = 1'b0; DataC1 = 1'b0; DataD1 = 1'b0;
        #2;
        check("add2 out_0", out_0, 1'b1);
        check("add2 out_2", out_2, 1'b0);
        check("add2 carry_out", carry_out, 1'b0);
        step();
        carry_in = 1'b0; DataA = 1'b1; DataB = 1'b1; DataC1 = 1'b1; DataD1 = 1'b1;
        #2;
        check("add3 out_0", out_0, 1'b0);
        check("add3 out_2", out_2, 1'b1);
        check("add3 carry_out", carry_out, 1'b1);
        step();

        // Normal mode, L0=A, reg1 bypass from DataF
        cv = '0;
        cv[15:0] = 16'hAAAA;
        cv[77] = 1'b1;
        shift_cfg(cv, -1);
        {DataA, DataB, DataC0, DataC1, DataD0, DataD1, DataE, DataF} = 8'h00;
        carry_in = 1'b0;
        DataA = 1'b1;
        #2;
        check("normal out_0", out_0, 1'b1);
        check("normal carry_out", carry_out, 1'b0);
        clk_en_0 = 1'b1;
        step();
        clk_en_0 = 1'b0;
        check("reg0 load", out_1, 1'b1);
        clear_sync_0 = 1'b1;
        clk_en_0 = 1'b1;
        step();
        clear_sync_0 = 1'b0;
        check("clear_sync_0 over en", out_1, 1'b0);
        DataF = 1'b1;
        clk_en_1 = 1'b1;
        step();
        check("reg0 reload", out_1, 1'b1);
        check("reg1 bypass F", out_3, 1'b1);
        check("bypass comb1", out_2, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        clk_en_0 = 1'b0;
        clk_en_1 = 1'b0;
        check("clear out_1", out_1, 1'b0);
        check("clear out_3", out_3, 1'b0);
        check("clear keeps cfg", out_0, 1'b1);
        step();

        // Clear during shifting; reg0 bypass from DataE
        cv = '0;
        cv[15:0] = 16'hAAAA;
        cv[76] = 1'b1;
        shift_cfg(cv, 40);
        DataA = 1'b1; DataE = 1'b1; DataF = 1'b0;
        #2;
        check("E selects L1", out_0, 1'b0);
        clk_en_0 = 1'b1;
        step();
        clk_en_0 = 1'b0;
        check("reg0 bypass E", out_1, 1'b1);
        DataE = 1'b0;
        #2;
        check("shift under clear", out_0, 1'b1);
        step();
        step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alm_cell.md
ALM_CELL -- requirements
Module: alm_cell

Interface
REQ-001 SHALL have parameter param_XOR6_en, default 1, meaning the dedicated XOR6 gate and its config bit are present.
REQ-002 SHALL have parameter param_MajAdd_en, default 0, meaning the majority-add config bit is present.
REQ-003 SHALL have parameter param_fixed, default 1, meaning the output routing is fixed rather than configurable.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock for all state, including the configuration chain.
REQ-005 clear  in  1  synchronous active-high reset.
REQ-006 clear_sync_0, clear_sync_1  in  1 each  per-register synchronous clear.
REQ-007 clk_en_0, clk_en_1  in  1 each  per-register clock enable.
REQ-008 DataA, DataB, DataC0, DataC1, DataD0, DataD1, DataE, DataF  in  1 each  logic inputs.
REQ-009 carry_in  in  1, carry_out  out  1  carry chain.
REQ-010 out_0, out_1, out_2, out_3  out  1 each  results.
REQ-011 config_in, config_en  in  1 each, config_out  out  1  serial bitstream port.

Function
REQ-012 Bitstream length SHALL be N = 86 + (param_XOR6_en|param_MajAdd_en) + param_MajAdd_en.
REQ-013 When config_en=1 at a clk edge, cfg SHALL shift: cfg <= {cfg[N-2:0], config_in}, so the first bit sent (MSB-first) ends at cfg[N-1]. When config_en=0, cfg SHALL hold.
REQ-014 Layout SHALL be: [63:0] = four 16-bit LUTs, with L0=[15:0] ... L3=[63:48]; [64] mode6; [65] arith; [69:66] out_3..out_0 source select (1=register); [76] reg0 D=DataE bypass; [77] reg1 D=DataF bypass; [85:70] (except 76,77) reserved; [86] xor6; [87] majadd.
REQ-015 L0 and L1 SHALL be indexed by {DataD0,DataC0,DataB,DataA}; L2 and L3 SHALL be indexed by {DataD1,DataC1,DataB,DataA}.
REQ-016 Normal mode SHALL compute comb0 = DataE ? L1 : L0 and comb1 = DataF ? L3 : L2.
REQ-017 When mode6=1, L0..L3 SHALL all be indexed by {DataD0,DataC0,DataB,DataA}, and comb1 SHALL be L[{DataF,DataE}], forming a 6-LUT over index {F,E,D0,C0,B,A}; comb0 SHALL follow REQ-016.
REQ-018 When arith=1 (mode6=0): sum0/c1 = full-add(L0, L1, cin0) and sum1/carry_out = full-add(L2, L3, c1). comb0 SHALL be sum0 and comb1 SHALL be sum1. cin0 SHALL be carry_in, or DataE when majadd=1 and param_MajAdd_en=1.
REQ-019 When arith=0, carry_out SHALL be 0.
REQ-020 When xor6=1 and param_XOR6_en=1, comb0 SHALL be A^B^C0^D0^E^F, overriding every mode.
REQ-021 reg0 D SHALL be comb0 (or DataE if [76]=1); reg1 D SHALL be comb1 (or DataF if [77]=1).
REQ-022 Register update priority per edge SHALL be: clear, then clear_sync_k (set to 0), then clk_en_k (load), otherwise hold.
REQ-023 When param_fixed=1: out_0=comb0, out_1=reg0, out_2=comb1, out_3=reg1. When param_fixed=0: out_k SHALL be reg (reg0 for k=0,1; reg1 for k=2,3) if cfg[66+k]=1, else the corresponding comb.
REQ-024 Comb paths SHALL be purely combinational, with zero-cycle latency from the Data inputs.

Reset
REQ-025 clear=1 at an edge SHALL set reg0 and reg1 to 0, so out_1 and out_3 read 0 with the fixed routing.
REQ-026 clear SHALL NOT alter cfg; cfg powers up undefined until it is shifted.
REQ-027 A clear asserted during shifting SHALL leave shifting unaffected.

Configuration
REQ-028 Macro ALM_CONFIG_OUT_EN: when defined, config_out SHALL be cfg[N-1] (for daisy-chaining); when undefined, config_out SHALL be tied to 0 and no readback logic is built.

Verification
REQ-029 XOR6=1, mode6=1, LUT bit i = bit1 of popcount(i), 87 bits shifted, then {F,E,D0,C0,B,A}=101101 -> out_0=0, out_2=0; 000111 -> out_0=1, out_2=1; 100 random vectors -> out_0=popcount[0], out_2=popcount[1].
REQ-030 arith=1, L0=A, L1=B, L2=C1, L3=D1, carry_in=1, A=B=1, C1=1, D1=0 -> out_0=1, out_2=0, carry_out=1.
REQ-031 Normal mode, L0=16'hAAAA, L1=0, E=0, A=1 -> out_0=1; after one edge with clk_en_0=1 -> out_1=1; clear_sync_0=1 -> out_1=0 next edge.
REQ-032 clear=1 with clk_en=1 -> out_1=out_3=0 next edge; cfg unchanged (out_0 still correct).
REQ-033 With ALM_CONFIG_OUT_EN defined, shift N+3 bits -> config_out replays the first 3 bits delayed by N cycles; config_en=0 -> config_out constant.
